ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS-style pipeline, between decode and memory. It latches the ID/EX pipeline register on each clock and computes, combinationally from the latched values:
- the ALU result and zero flag;
- the destination register number;
- the branch target address.

Control fields for the later stages pass straight through from the register.

---
 rtl/pipe_pkg.sv | 42 ++++
 rtl/ex_stage_if.sv | 39 +++
 rtl/adder_32.sv | 14 +
 rtl/alu.sv | 38 +++
 rtl/mux_2to1_n.sv | 13 +
 rtl/ex_stage.sv | 90 +++++++++
 tb/tb_ex_stage.sv | 238 +++++++++++++++++++++++
 7 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes and the ID/EX register layout.
package pipe_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SUBU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b1101;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic        regDst;
        logic        aluSrc;
        logic        memToReg;
        logic        regWrite;
        logic        memWr;
        logic        branch;
        logic        jump;
        logic        loadext;
        logic        jal;
        logic [3:0]  aluCtrl;
        logic [1:0]  fPoint;
        logic [1:0]  dSize;
        logic [31:0] imm32;
        logic [31:0] busA;
        logic [31:0] busB;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [31:0] delayslot;
        logic [31:0] delayslot2;
    } idEx_t;

endpackage

// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle: d* fields from decode, execute results towards memory.
interface ex_stage_if;

    logic        dRegDst, dALUSrc, dMemToReg, dRegWrite, dMemWr;
    logic        dBranch, dJump, dLoadext, dJal;
    logic [3:0]  dAluCtrl;
    logic [1:0]  dFPoint, dDsize;
    logic [31:0] dImm32, dBusA, dBusB;
    logic [4:0]  dRd, dRt;
    logic [31:0] dDelayslot, dDelayslot2;

    logic        MemWr, Branch, MemtoReg, RegWr, Jump, Loadext, Jal;
    logic [1:0]  FPoint, Dsize;
    logic [31:0] BusB;
    logic [31:0] Delayslot2;
    logic [31:0] ALUout;
    logic        Zero;
    logic [4:0]  Rw;
    logic [31:0] BranchTarget;

    // Decode side: drives the d* fields, observes the execute results.
    modport master (
        output dRegDst, dALUSrc, dMemToReg, dRegWrite, dMemWr,
               dBranch, dJump, dLoadext, dJal, dAluCtrl, dFPoint, dDsize,
               dImm32, dBusA, dBusB, dRd, dRt, dDelayslot, dDelayslot2,
        input  MemWr, Branch, MemtoReg, RegWr, Jump, Loadext, Jal,
               FPoint, Dsize, BusB, Delayslot2, ALUout, Zero, Rw, BranchTarget
    );

    // Execute stage side.
    modport slave (
        input  dRegDst, dALUSrc, dMemToReg, dRegWrite, dMemWr,
               dBranch, dJump, dLoadext, dJal, dAluCtrl, dFPoint, dDsize,
               dImm32, dBusA, dBusB, dRd, dRt, dDelayslot, dDelayslot2,
        output MemWr, Branch, MemtoReg, RegWr, Jump, Loadext, Jal,
               FPoint, Dsize, BusB, Delayslot2, ALUout, Zero, Rw, BranchTarget
    );

endinterface

// File: rtl/adder_32.sv
// Ripple-free behavioural adder with carry in and carry out.
module adder_32 #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU; unused opcodes yield zero. No overflow detection.
module alu
    import pipe_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0] shamt;
    assign shamt = a[4:0];

    // Operation select; the default-first assignment keeps this purely combinational.
    always_comb begin
        // NOTE: assigning a default before the case guarantees no latch for uncovered codes.
        result = 32'h0;
        case (ctrl)
            ALU_AND:            result = a & b;
            ALU_OR:             result = a | b;
            ALU_ADD, ALU_ADDU:  result = a + b;
            ALU_XOR:            result = a ^ b;
            ALU_NOR:            result = ~(a | b);
            ALU_SUB, ALU_SUBU:  result = a - b;
            ALU_SLT:            result = {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU:           result = {31'h0, a < b};
            ALU_SLL:            result = b << shamt;
            ALU_SRL:            result = b >> shamt;
            ALU_SRA:            result = $unsigned($signed(b) >>> shamt);
            ALU_LUI:            result = {b[15:0], 16'h0};
            default:            result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/mux_2to1_n.sv
// Generic two-input multiplexer; sel=1 picks in1.
module mux_2to1_n #(
    parameter int n = 32
) (
    input  logic [n-1:0] in0,
    input  logic [n-1:0] in1,
    input  logic         sel,
    output logic [n-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register plus ALU, destination select and branch target adder.
module ex_stage
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    idEx_t       idEx;
    logic [31:0] aluB;
    logic [31:0] immShifted;
    logic        brCoutUnused;

    // ID/EX pipeline register: unconditional capture, async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments so every field samples pre-edge values.
        if (!rst_n) begin
            idEx <= '0;
        end else begin
            idEx.regDst     <= bus.dRegDst;
            idEx.aluSrc     <= bus.dALUSrc;
            idEx.memToReg   <= bus.dMemToReg;
            idEx.regWrite   <= bus.dRegWrite;
            idEx.memWr      <= bus.dMemWr;
            idEx.branch     <= bus.dBranch;
            idEx.jump       <= bus.dJump;
            idEx.loadext    <= bus.dLoadext;
            idEx.jal        <= bus.dJal;
            idEx.aluCtrl    <= bus.dAluCtrl;
            idEx.fPoint     <= bus.dFPoint;
            idEx.dSize      <= bus.dDsize;
            idEx.imm32      <= bus.dImm32;
            idEx.busA       <= bus.dBusA;
            idEx.busB       <= bus.dBusB;
            idEx.rd         <= bus.dRd;
            idEx.rt         <= bus.dRt;
            idEx.delayslot  <= bus.dDelayslot;
            idEx.delayslot2 <= bus.dDelayslot2;
        end
    end

    // Control fields consumed by the memory and writeback stages.
    assign bus.MemWr      = idEx.memWr;
    assign bus.Branch     = idEx.branch;
    assign bus.MemtoReg   = idEx.memToReg;
    assign bus.RegWr      = idEx.regWrite;
    assign bus.Jump       = idEx.jump;
    assign bus.Loadext    = idEx.loadext;
    assign bus.Jal        = idEx.jal;
    assign bus.FPoint     = idEx.fPoint;
    assign bus.Dsize      = idEx.dSize;
    assign bus.BusB       = idEx.busB;
    assign bus.Delayslot2 = idEx.delayslot2;

    mux_2to1_n #(.n(32)) uAluSrcMux (
        .in0 (idEx.busB),
        .in1 (idEx.imm32),
        .sel (idEx.aluSrc),
        .out (aluB)
    );

    mux_2to1_n #(.n(5)) uRegDstMux (
        .in0 (idEx.rt),
        .in1 (idEx.rd),
        .sel (idEx.regDst),
        .out (bus.Rw)
    );

    alu uAlu (
        .a      (idEx.busA),
        .b      (aluB),
        .ctrl   (idEx.aluCtrl),
        .result (bus.ALUout),
        .zero   (bus.Zero)
    );

    // Word offset to byte offset; the top two immediate bits fall off.
    assign immShifted = {idEx.imm32[29:0], 2'b00};

    // Carry-out is dropped so the target wraps modulo 2^32.
    adder_32 #(.N(32)) uBranchAdder (
        .a    (idEx.delayslot),
        .b    (immShifted),
        .cin  (1'b0),
        .sum  (bus.BranchTarget),
        .cout (brCoutUnused)
    );

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes model predictions, monitor pops and compares.
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_stage_if bus ();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ctl;   // regDst aluSrc memToReg regWrite memWr branch jump loadext jal
        logic [3:0]  op;
        logic [1:0]  fp, ds;
        logic [31:0] imm, a, b;
        logic [4:0]  rd, rt;
        logic [31:0] slot, slot2;
    } txn_t;

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [4:0]  rw;
        logic [31:0] bt;
        logic [6:0]  pass;  // MemWr Branch MemtoReg RegWr Jump Loadext Jal
        logic [1:0]  fp, ds;
        logic [31:0] busB, slot2;
    } exp_t;

    exp_t expQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model straight from the instruction semantics.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        logic [31:0] opB;
        int unsigned sh;
        opB = t.ctl[7] ? t.imm : t.b;
        sh  = int'(t.a % 32);
        case (t.op)
            4'd0:       e.alu = t.a & opB;
            4'd1:       e.alu = t.a | opB;
            4'd2, 4'd3: e.alu = t.a + opB;
            4'd4:       e.alu = t.a ^ opB;
            4'd5:       e.alu = ~(t.a | opB);
            4'd6, 4'd7: e.alu = t.a - opB;
            4'd8:       e.alu = (int'(t.a) < int'(opB)) ? 32'd1 : 32'd0;
            4'd9:       e.alu = (t.a < opB) ? 32'd1 : 32'd0;
            4'd10:      e.alu = opB << sh;
            4'd11:      e.alu = opB >> sh;
            4'd12:      e.alu = opB[31] ? ~((~opB) >> sh) : (opB >> sh);
            4'd13:      e.alu = opB * 32'h10000;
            default:    e.alu = 32'h0;
        endcase
        e.zero  = (e.alu == 0);
        e.rw    = t.ctl[8] ? t.rd : t.rt;
        e.bt    = t.slot + t.imm * 4;
        e.pass  = {t.ctl[4], t.ctl[3], t.ctl[6], t.ctl[5], t.ctl[2], t.ctl[1], t.ctl[0]};
        e.fp    = t.fp;
        e.ds    = t.ds;
        e.busB  = t.b;
        e.slot2 = t.slot2;
        return e;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.ctl   = 9'($urandom);
        t.op    = 4'($urandom);
        t.fp    = 2'($urandom);
        t.ds    = 2'($urandom);
        t.imm   = $urandom;
        t.a     = ($urandom_range(0, 3) == 0) ? 32'(t.op) : $urandom;
        t.b     = ($urandom_range(0, 3) == 0) ? t.a : $urandom;
        t.rd    = 5'($urandom);
        t.rt    = 5'($urandom);
        t.slot  = $urandom;
        t.slot2 = $urandom;
        return t;
    endfunction

    function automatic txn_t mk(input logic [3:0] op, input logic aluSrc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] imm);
        txn_t t;
        t       = rand_txn();
        t.op    = op;
        t.ctl[7] = aluSrc;
        t.a     = a;
        t.b     = b;
        t.imm   = imm;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        {bus.dRegDst, bus.dALUSrc, bus.dMemToReg, bus.dRegWrite, bus.dMemWr,
         bus.dBranch, bus.dJump, bus.dLoadext, bus.dJal} = t.ctl;
        bus.dAluCtrl    = t.op;
        bus.dFPoint     = t.fp;
        bus.dDsize      = t.ds;
        bus.dImm32      = t.imm;
        bus.dBusA       = t.a;
        bus.dBusB       = t.b;
        bus.dRd         = t.rd;
        bus.dRt         = t.rt;
        bus.dDelayslot  = t.slot;
        bus.dDelayslot2 = t.slot2;
    endtask

    task automatic issue(input txn_t t);
        @(negedge clk);
        drive(t);
        expQ.push_back(model(t));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expQ.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding after 10 cycles", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pass"},  {25'h0, bus.MemWr, bus.Branch, bus.MemtoReg, bus.RegWr,
                                bus.Jump, bus.Loadext, bus.Jal}, 32'h0);
        check({tag, "_fpds"},  {28'h0, bus.FPoint, bus.Dsize}, 32'h0);
        check({tag, "_busB"},  bus.BusB, 32'h0);
        check({tag, "_slot2"}, bus.Delayslot2, 32'h0);
        check({tag, "_alu"},   bus.ALUout, 32'h0);
        check({tag, "_zero"},  {31'h0, bus.Zero}, 32'h1);
        check({tag, "_rw"},    {27'h0, bus.Rw}, 32'h0);
        check({tag, "_bt"},    bus.BranchTarget, 32'h0);
    endtask

    // Monitor: one registered result per clock while expectations are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && expQ.size() > 0) begin
                e = expQ.pop_front();
                check("alu",   bus.ALUout, e.alu);
                check("zero",  {31'h0, bus.Zero}, {31'h0, e.zero});
                check("rw",    {27'h0, bus.Rw}, {27'h0, e.rw});
                check("bt",    bus.BranchTarget, e.bt);
                check("pass",  {25'h0, bus.MemWr, bus.Branch, bus.MemtoReg, bus.RegWr,
                                bus.Jump, bus.Loadext, bus.Jal}, {25'h0, e.pass});
                check("fpds",  {28'h0, bus.FPoint, bus.Dsize}, {28'h0, e.fp, e.ds});
                check("busB",  bus.BusB, e.busB);
                check("slot2", bus.Delayslot2, e.slot2);
            end
        end
    end

    initial begin
        txn_t t;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(rand_txn());
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the instruction semantics.
        issue(mk(4'b0010, 1'b1, 32'd5, $urandom, 32'd7));
        issue(mk(4'b0110, 1'b0, 32'h1234, 32'h1234, $urandom));
        issue(mk(4'b1000, 1'b0, 32'hFFFFFFFF, 32'd1, $urandom));
        issue(mk(4'b1001, 1'b0, 32'hFFFFFFFF, 32'd1, $urandom));
        issue(mk(4'b1011, 1'b0, 32'd4, 32'h80000000, $urandom));
        issue(mk(4'b1100, 1'b0, 32'd4, 32'h80000000, $urandom));
        issue(mk(4'b1010, 1'b0, 32'd4, 32'h80000000, $urandom));
        issue(mk(4'b1101, 1'b1, $urandom, $urandom, 32'hABCD1234));
        issue(mk(4'b1110, 1'b0, $urandom, $urandom, $urandom));
        issue(mk(4'b1111, 1'b1, $urandom, $urandom, $urandom));
        t = mk(4'b0001, 1'b0, 32'h1, 32'h2, 32'hFFFFFFFF);
        t.rt = 5'd3; t.rd = 5'd9; t.ctl[8] = 1'b1; t.slot = 32'h100;
        issue(t);
        t.ctl[8] = 1'b0;
        issue(t);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) issue(rand_txn());
        drain();

        // Mid-cycle reset: the registered instruction is discarded immediately.
        @(negedge clk);
        t = mk(4'b0001, 1'b1, 32'h5A5A0000, 32'h1, 32'h00000011);
        t.ctl = 9'h1FF;
        drive(t);
        @(posedge clk);
        #2;
        check("pre_reset_alu", bus.ALUout, 32'h5A5A0011);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("release");

        for (int i = 0; i < 50; i++) issue(rand_txn());
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
